// File: rtl/ones_seq_ctrl.sv
// ones_seq_ctrl: sequences an external serial ones-counter (clear, count, timeout) and holds the corrected result.
module ones_seq_ctrl #(
    parameter int TIMEOUT    = 24,
    parameter int CLR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        cnt_clr,
    output logic [15:0] cnt_a,
    input  logic [3:0]  cnt_ones,
    input  logic        cnt_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_ones,
    output logic        out_err
);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, COUNT, HOLD} state_t;

    state_t        state, next;
    logic [15:0]   word;
    logic [CW-1:0] clr_cnt;
    logic [TW-1:0] cyc;
    logic          clr_last, time_up;

    assign clr_last  = clr_cnt == CW'(CLR_CYCLES - 1);
    assign time_up   = cyc == TW'(TIMEOUT - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == HOLD;
    // Reset also drives the clear so the downstream counter stays cleared while held.
    assign cnt_clr   = reset || state == CLEAR;
    assign cnt_a     = word;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? CLEAR : IDLE;
            CLEAR:   next = clr_last ? COUNT : CLEAR;
            COUNT:   next = (cnt_done || time_up) ? HOLD : COUNT;
            HOLD:    next = out_ready ? IDLE : HOLD;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word     <= '0;
            clr_cnt  <= '0;
            cyc      <= '0;
            out_ones <= '0;
            out_err  <= 1'b0;
        end else begin
            state   <= next;
            clr_cnt <= (state == CLEAR) ? clr_cnt + CW'(1) : '0;
            cyc     <= (state == COUNT) ? cyc + TW'(1) : '0;
            if (state == IDLE && in_valid)
                word <= in_data;
            // cnt_done takes priority over a coincident timeout.
            if (state == COUNT && cnt_done) begin
                out_ones <= {word == 16'hFFFF, cnt_ones};
                out_err  <= 1'b0;
            end else if (state == COUNT && time_up) begin
                out_ones <= '0;
                out_err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ones_seq_ctrl.sv
// tb_ones_seq_ctrl: random words and counter latencies against a transaction-level reference model.
module tb_ones_seq_ctrl;
    localparam int TIMEOUT    = 24;
    localparam int CLR_CYCLES = 2;

    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [15:0] in_data = '0;
    logic        in_ready, cnt_clr, cnt_done, out_valid, out_err;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_ones;
    logic [4:0]  out_ones;
    int          n_chk = 0, n_pass = 0;
    int          lat_r = 1000;
    int          k = 0;

    ones_seq_ctrl #(.TIMEOUT(TIMEOUT), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cnt_clr(cnt_clr), .cnt_a(cnt_a), .cnt_ones(cnt_ones), .cnt_done(cnt_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_ones(out_ones), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Serial counter model: finishes lat_r cycles after its clear drops, reporting the 4-bit popcount.
    always @(posedge clk) k <= cnt_clr ? 0 : k + 1;
    assign cnt_done = !cnt_clr && k == lat_r;
    assign cnt_ones = cnt_done ? 4'($countones(cnt_a)) : 4'(k);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic xfer(input logic [15:0] w, input int lat, input int hold);
        int clr_n = 0, cnt_n = 0, t = 0;
        bit bad_ready = 0, bad_a = 0;
        logic [4:0] e_ones = lat < TIMEOUT ? 5'($countones(w)) : 5'd0;
        logic       e_err  = lat >= TIMEOUT;
        int         e_cnt  = lat < TIMEOUT ? lat + 1 : TIMEOUT;
        chk("idle_ready", in_ready, 1);
        lat_r = lat;
        in_valid = 1;
        in_data = w;
        @(negedge clk);
        in_valid = 0;
        in_data = $urandom;
        while (!out_valid && t < 200) begin
            if (cnt_clr) clr_n++; else cnt_n++;
            if (in_ready) bad_ready = 1;
            if (cnt_a !== w) bad_a = 1;
            @(negedge clk);
            t++;
        end
        chk("out_valid", out_valid, 1);
        chk("clr_cycles", clr_n, CLR_CYCLES);
        chk("count_cycles", cnt_n, e_cnt);
        chk("busy_ready", bad_ready, 0);
        chk("cnt_a_stable", bad_a, 0);
        chk("out_ones", out_ones, e_ones);
        chk("out_err", out_err, e_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", {in_ready, out_valid, out_err, out_ones, cnt_a}, {1'b0, 1'b1, e_err, e_ones, w});
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("back_idle", {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #1;
        chk("rst_outs", {in_ready, cnt_clr, out_valid, out_ones, out_err, cnt_a}, {1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0});
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("idle_clr", {cnt_clr, out_valid}, 2'b00);
        xfer(16'hA5A5, 8, 0);
        xfer(16'hFFFF, 16, 0);
        xfer(16'h0000, 3, 0);
        xfer(16'h1234, 1000, 0);
        xfer(16'h7FFF, TIMEOUT - 1, 0);
        xfer(16'h00FF, TIMEOUT, 0);
        xfer(16'h0F0F, 0, 0);
        xfer(16'hC3C3, 5, 5);
        // Reset mid-COUNT must drop the word silently.
        lat_r = 1000;
        in_valid = 1;
        in_data = 16'hBEEF;
        @(negedge clk);
        in_valid = 0;
        repeat (CLR_CYCLES + 3) @(negedge clk);
        reset = 1;
        #1;
        chk("rst_mid", {in_ready, cnt_clr, out_valid, out_ones, out_err, cnt_a}, {1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0});
        @(negedge clk);
        reset = 0;
        begin
            bit seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (out_valid) seen = 1;
                @(negedge clk);
            end
            chk("no_result_after_rst", seen, 0);
        end
        xfer(16'h000F, 6, 0);
        for (int i = 0; i < 25; i++)
            xfer(16'($urandom), $urandom_range(0, 30), $urandom_range(0, 3));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ones_seq_ctrl.md
ONES_SEQ_CTRL -- requirements
Module: ones_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 24: maximum cycles in COUNT waiting for cnt_done before the count is aborted.
REQ-002 Parameter CLR_CYCLES, default 2: number of cycles cnt_clr is held high per word.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: upstream word available.
REQ-006 Port in_ready, output, 1: block can accept a word.
REQ-007 Port in_data, input, 16: word whose ones are to be counted.
REQ-008 Port cnt_clr, output, 1: drives the serial ones-counter's synchronous clear.
REQ-009 Port cnt_a, output, 16: word presented to the serial ones-counter.
REQ-010 Port cnt_ones, input, 4: running or final count from the ones-counter.
REQ-011 Port cnt_done, input, 1: ones-counter end flag.
REQ-012 Port out_valid, output, 1: result available.
REQ-013 Port out_ready, input, 1: downstream accepts the result.
REQ-014 Port out_ones, output, 5: corrected ones count, 0..16.
REQ-015 Port out_err, output, 1: result aborted by timeout; qualified by out_valid.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, COUNT and HOLD.
REQ-017 IDLE: in_ready=1; in_valid=1 SHALL latch in_data into a 16-bit word register and move to CLEAR on the same edge.
REQ-018 in_ready SHALL be 0 in CLEAR, COUNT and HOLD; no input buffering beyond the one word register.
REQ-019 CLEAR: cnt_clr=1 for exactly CLR_CYCLES cycles, counted by a clear counter, then move to COUNT.
REQ-020 cnt_a SHALL equal the word register at all times and SHALL stay stable from the IDLE->CLEAR edge until HOLD is left.
REQ-021 COUNT: cnt_clr=0; a cycle counter starts at 0 on entry and increments each cycle.
REQ-022 In COUNT, cnt_done=1 SHALL capture the result and move to HOLD; cnt_done SHALL be ignored in all other states.
REQ-023 Result width correction: out_ones = {(word==16'hFFFF), cnt_ones}; for word 16'hFFFF the 4-bit count wraps to 0 and out_ones SHALL be 16.
REQ-024 If the cycle counter reaches TIMEOUT without cnt_done, the block SHALL move to HOLD with out_err=1 and out_ones=0.
REQ-025 If cnt_done and the timeout occur in the same cycle, cnt_done SHALL win and out_err=0.
REQ-026 HOLD: out_valid=1; out_ones and out_err SHALL stay stable until out_ready=1.
REQ-027 In HOLD, out_ready=1 SHALL move to IDLE; the next word is accepted at the earliest one cycle later.
REQ-028 Throughput: one word per (1 + CLR_CYCLES + count latency + 1) cycles when out_ready is held at 1.
REQ-029 out_valid SHALL be 0 in IDLE, CLEAR and COUNT.

Reset
REQ-030 reset=1 SHALL force IDLE asynchronously, with in_ready=1, cnt_clr=1, out_valid=0, out_ones=0, out_err=0, and the word, clear and cycle counters all at 0.
REQ-031 Holding cnt_clr high during reset keeps the downstream counter cleared.
REQ-032 Reset asserted in any state SHALL discard the in-flight word without producing a result.
REQ-033 On reset release, the first edge SHALL evaluate IDLE.

Verification
REQ-034 Word 16'hA5A5 with a counter model returning 8 -> out_valid with out_ones=8, out_err=0; in_ready=0 throughout.
REQ-035 Word 16'hFFFF with the counter returning 0 plus cnt_done -> out_ones=16, out_err=0.
REQ-036 Word 16'h0000 -> out_ones=0, out_err=0; cnt_clr high for exactly 2 cycles.
REQ-037 cnt_done held low -> out_valid exactly TIMEOUT cycles after entering COUNT, with out_err=1 and out_ones=0.
REQ-038 Result with out_ready low for 5 cycles -> out_ones stable and in_ready=0 for all 5 cycles; IDLE one cycle after out_ready rises.
REQ-039 reset pulsed during COUNT -> out_valid never asserts for that word; the next word 16'h000F yields out_ones=4.
